// File: rtl/v6502_pkg.sv
// rtl/v6502_pkg.sv - shared 6502 core constants
// Purpose: constants shared by the fetch/decode path. The instruction length
//   limit sets the decoder's retire width and the addr_mode inst_len range.
// Ports: none (package).
package v6502_pkg;

  // Longest 6502 instruction: opcode plus a two-byte operand.
  localparam int INST_MAX_LEN = 3;
  // Width of one opcode/operand byte.
  localparam int BYTE_W       = 8;

endpackage

// File: rtl/queue_peek_window.sv
// rtl/queue_peek_window.sv - combinational peek window over the prefetch queue
// Purpose: presents the oldest MAX_PULL entries starting at rd_ptr. The window
//   wraps seamlessly past DEPTH-1, and lanes beyond the current occupancy read
//   as zero.
// Ports:
//   mem        in   DEPTH x DATA_W   queue storage
//   rd_ptr     in   AW               index of the oldest entry
//   count      in   AW+1             current occupancy
//   peek_data  out  MAX_PULL*DATA_W  oldest entry in the low lane
//   peek_count out  PW               min(count, MAX_PULL)
module queue_peek_window
  import v6502_pkg::*;
#(
  parameter int DATA_W   = BYTE_W,
  parameter int DEPTH    = 16,
  parameter int MAX_PULL = INST_MAX_LEN,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = $clog2(MAX_PULL + 1)
) (
  input  logic [DATA_W-1:0]          mem [DEPTH],
  input  logic [AW-1:0]              rd_ptr,
  input  logic [AW:0]                count,
  output logic [MAX_PULL*DATA_W-1:0] peek_data,
  output logic [PW-1:0]              peek_count
);

  assign peek_count = (count >= (AW+1)'(MAX_PULL)) ? PW'(MAX_PULL) : count[PW-1:0];

  // The AW-bit sum wraps modulo DEPTH, so the window crosses the end of the
  // storage without any special case.
  always_comb begin
    peek_data = '0;
    for (int i = 0; i < MAX_PULL; i++) begin
      if (PW'(i) < peek_count) begin
        peek_data[i*DATA_W +: DATA_W] = mem[rd_ptr + AW'(i)];
      end
    end
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - instruction prefetch byte queue
// Purpose: byte FIFO between fetch and decode. Fetch pushes one byte per
//   cycle, the decoder peeks the oldest MAX_PULL bytes and retires a whole
//   instruction (1..MAX_PULL bytes) per cycle, and flush empties the queue.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   flush                 discard all entries; overrides push and pull
//   push_valid/push_data  byte offered by fetch
//   push_ready            queue can accept a byte (!full)
//   pull_len              bytes to retire this cycle (0 = none)
//   peek_data/peek_count  oldest bytes and how many lanes are valid
//   count/full/empty      occupancy status
//   pull_err              one-cycle pulse after a rejected nonzero pull
module inst_prefetch_queue
  import v6502_pkg::*;
#(
  parameter int DATA_W   = BYTE_W,
  parameter int DEPTH    = 16,
  parameter int MAX_PULL = INST_MAX_LEN,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = $clog2(MAX_PULL + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push_valid,
  input  logic [DATA_W-1:0]          push_data,
  output logic                       push_ready,
  input  logic [PW-1:0]              pull_len,
  output logic [MAX_PULL*DATA_W-1:0] peek_data,
  output logic [PW-1:0]              peek_count,
  output logic [AW:0]                count,
  output logic                       full,
  output logic                       empty,
  output logic                       pull_err
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              push_acc;
  logic              pull_req;
  logic              pull_ok;
  logic [AW:0]       pull_amt;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  // Readiness looks only at the registered count: a full queue refuses a push
  // even when the same cycle retires bytes.
  assign push_ready = !full;

  assign push_acc = push_valid && push_ready && !flush;
  assign pull_req = (pull_len != '0);
  assign pull_ok  = pull_req && !flush
                    && (pull_len <= PW'(MAX_PULL))
                    && ((AW+1)'(pull_len) <= count);
  assign pull_amt = pull_ok ? (AW+1)'(pull_len) : '0;

  // Storage needs no reset; lanes past the occupancy are masked at the peek.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pull_err <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pull_err <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pull_ok) begin
        rd_ptr <= rd_ptr + AW'(pull_len);
      end
      // A legal pull is bounded by the pre-edge count, so a byte pushed this
      // cycle is never retired in the same cycle.
      count    <= count + (AW+1)'(push_acc) - pull_amt;
      pull_err <= pull_req && !pull_ok;
    end
  end

  queue_peek_window #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .MAX_PULL (MAX_PULL)
  ) u_peek (
    .mem        (mem),
    .rd_ptr     (rd_ptr),
    .count      (count),
    .peek_data  (peek_data),
    .peek_count (peek_count)
  );

endmodule
